alarm_btn_conditioner: RTL
==========================

Name: alarm_btn_conditioner

Overview:
- Conditions the three raw push-buttons (UP, DOWN, SET) of the alarm clock before they reach the btn_up_export, btn_down_export and btn_set_export inputs of the alarm_clk system.
- Each button gets a 2-FF synchronizer, a counter-based debouncer and a one-cycle press pulse.
- UP and DOWN also get hold-to-auto-repeat, so time/alarm values can be scrolled quickly.
- Sits directly upstream of the system; pulses feed edge-capture PIOs, and levels are exported for status.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized input must hold a new value before the debounced level follows (20 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, cycles from the press pulse to the first auto-repeat pulse (500 ms); must be > REPEAT_PERIOD.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (100 ms); must be >= 2.
- RAW_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (board KEYs); 0 = active-high.

Ports:
- clk_clk  input  1  system clock.
- reset_reset_n  input  1  asynchronous, active-low reset.
- key_up_raw  input  1  raw UP key, asynchronous to clk_clk.
- key_down_raw  input  1  raw DOWN key, asynchronous.
- key_set_raw  input  1  raw SET key, asynchronous.
- btn_up_pulse  output  1  one-cycle pulse on UP press and on each UP auto-repeat.
- btn_down_pulse  output  1  one-cycle pulse on DOWN press and on each DOWN auto-repeat.
- btn_set_pulse  output  1  one-cycle pulse on SET press only (no repeat).
- btn_up_level  output  1  debounced UP level, 1 = pressed.
- btn_down_level  output  1  debounced DOWN level, 1 = pressed.
- btn_set_level  output  1  debounced SET level, 1 = pressed.

Behaviour:
- Clock and reset: single clock, clk_clk. Reset is asynchronous, active-low, on reset_reset_n.
- Reset state:
  - All outputs 0, all counters 0, all FSMs IDLE.
  - Synchronizer flops and debounced levels reset to the "released" value.
  - A key held through reset release is detected as a new press after debounce and produces one pulse.
- Synchronizer:
  - Raw input is inverted when RAW_ACTIVE_LOW=1, then passed through 2 flops, giving sync.
  - Raw-to-sync latency: 2 cycles.
- Debounce, per button:
  - Counter db_cnt clears whenever sync == level.
  - While sync != level, db_cnt increments each cycle.
  - At the cycle where db_cnt == DEBOUNCE_CYCLES-1 and sync != level still holds: level <= sync and db_cnt <= 0.
  - Total latency from a stable raw change to the level change: 2 + DEBOUNCE_CYCLES cycles.
  - Any sync glitch shorter than DEBOUNCE_CYCLES cycles is ignored and the counter restarts.
  - Counter width: clog2(DEBOUNCE_CYCLES); it never wraps.
- Press pulse:
  - Registered pulse, asserted for exactly 1 cycle.
  - Asserted the cycle after the debounced level rises, i.e. aligned with the first cycle that btn_*_level reads 1.
  - A falling level never produces a pulse.
- Repeat FSM (UP and DOWN only); states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on level rise. The press pulse is emitted and rpt_cnt is set to 0.
  - In HOLD, rpt_cnt increments each cycle. When rpt_cnt == REPEAT_DELAY-1: emit a pulse, clear rpt_cnt, go to REPEAT. The first repeat pulse therefore comes exactly REPEAT_DELAY cycles after the press pulse.
  - In REPEAT, emit a pulse every REPEAT_PERIOD cycles (same counting rule).
  - Any state -> IDLE on level fall. No pulse is emitted and rpt_cnt is cleared.
- Lockout (both held):
  - While btn_up_level and btn_down_level are both 1, both FSMs are held in HOLD with rpt_cnt = 0 and no repeat pulses occur.
  - Press pulses still occur. If both levels rise in the same cycle, both pulses fire.
  - When one key releases, the other restarts from HOLD with rpt_cnt = 0 and emits no immediate pulse.
- SET FSM: IDLE and PRESSED only; one pulse per debounced press.
- Rules common to all buttons:
  - Buttons are fully independent apart from the UP/DOWN lockout.
  - Pulses on different buttons may coincide.
  - Reset asserted mid-hold clears everything immediately (asynchronous). No pulse is emitted on reset deassertion.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, RAW_ACTIVE_LOW=1):
- Reset: hold reset_reset_n=0 with all keys released (1), then release -> all six outputs 0; no pulse over 50 idle cycles.
- Clean SET press: drive key_set_raw 1->0 at cycle 0 and hold 20 cycles -> btn_set_level=1 from cycle 6; btn_set_pulse=1 only at cycle 6; release -> level=0 at +6 cycles with no pulse.
- Bounce: key_up_raw toggles with low phases of 3 cycles, then stays low -> exactly one btn_up_pulse, 6 cycles after the final stable edge; no pulse from the glitches.
- Auto-repeat: hold key_down_raw low for 40 cycles -> btn_down_pulse at press cycle P, then at P+10, P+13, P+16, …; release -> pulses stop and level falls 6 cycles later.
- Lockout: hold UP, then press DOWN 4 cycles later, hold both 30 cycles, release UP -> one press pulse each and no repeats while both are held; DOWN's first repeat comes 10 cycles after UP's level falls.
- Reset mid-repeat: assert reset in REPEAT with key still held, deassert -> outputs 0 immediately; a single fresh press pulse 6 cycles after reset release, then repeats at +10.

Source files
------------

// File: rtl/alarm_btn_conditioner.sv
// Push-button front end for the alarm clock: per-key synchronizer, debouncer,
// press pulse, plus hold-to-auto-repeat on UP/DOWN with a both-held lockout.

module alarm_btn_chan #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit RAW_ACTIVE_LOW  = 1'b1,
    parameter bit HAS_REPEAT      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic lock,
    output logic level,
    output logic pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(REPEAT_DELAY);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_PRESSED} state_t;

    logic [1:0]    sync_ff;
    logic          sync;
    logic [DW-1:0] db_cnt;
    logic          db_done, lvl_rise, lvl_fall;
    state_t        state, state_nxt;
    logic [RW-1:0] rpt_cnt, rpt_nxt;
    logic          pulse_nxt;

    // sync_ff holds the key in pressed=1 polarity; reset is "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= '0;
        else        sync_ff <= {sync_ff[0], raw ^ RAW_ACTIVE_LOW};
    end
    assign sync = sync_ff[1];

    assign db_done  = (sync != level) && (db_cnt == DB_LAST);
    assign lvl_rise = db_done && sync;
    assign lvl_fall = db_done && !sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync == level) begin
            db_cnt <= '0;
        end else if (db_done) begin
            db_cnt <= '0;
            level  <= sync;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rpt_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rpt_cnt <= rpt_nxt;
            pulse   <= pulse_nxt;
        end
    end

    // Release wins over everything, so a repeat due on the release cycle is dropped
    always_comb begin
        state_nxt = state;
        rpt_nxt   = rpt_cnt;
        pulse_nxt = 1'b0;
        if (lvl_fall) begin
            state_nxt = S_IDLE;
            rpt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lvl_rise) begin
                        state_nxt = HAS_REPEAT ? S_HOLD : S_PRESSED;
                        rpt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    if (lock) begin
                        state_nxt = S_HOLD;
                        rpt_nxt   = '0;
                    end else if (rpt_cnt == ((state == S_HOLD) ? RD_LAST : RP_LAST)) begin
                        state_nxt = S_REPEAT;
                        rpt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end else begin
                        rpt_nxt = rpt_cnt + 1'b1;
                    end
                end
                S_PRESSED: ;
                default: state_nxt = S_IDLE;
            endcase
        end
    end
endmodule

module alarm_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic key_up_raw,
    input  logic key_down_raw,
    input  logic key_set_raw,
    output logic btn_up_pulse,
    output logic btn_down_pulse,
    output logic btn_set_pulse,
    output logic btn_up_level,
    output logic btn_down_level,
    output logic btn_set_level
);
    localparam int NUM_BTN = 3;

    // Index 0 = UP, 1 = DOWN, 2 = SET (no repeat)
    logic [NUM_BTN-1:0] raw_vec, lvl_vec, pls_vec;
    logic               ud_lock;

    assign raw_vec = {key_set_raw, key_down_raw, key_up_raw};
    assign ud_lock = lvl_vec[0] & lvl_vec[1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        alarm_btn_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW),
            .HAS_REPEAT      (i < 2)
        ) u_chan (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .raw   (raw_vec[i]),
            .lock  ((i < 2) ? ud_lock : 1'b0),
            .level (lvl_vec[i]),
            .pulse (pls_vec[i])
        );
    end

    assign {btn_set_pulse, btn_down_pulse, btn_up_pulse} = pls_vec;
    assign {btn_set_level, btn_down_level, btn_up_level} = lvl_vec;
endmodule
